mul_div_unit: RTL and testbench

- Iterative multiply/divide unit for the single-cycle/multicycle MIPS datapath. Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds results in internal HI/LO registers.
- Sits directly upstream of the writeback result 2-way mux: hi/lo feed the mux data inputs used by MFHI/MFLO.
- Controller stalls on busy.

---
 rtl/mul_div_unit.sv | 171 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO result registers.
// Optional abort input is enabled with `define MDU_ABORT_EN.
module mul_div_unit #(
   parameter int unsigned width = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   input  logic [width-1:0] wd,
   input  logic             hi_we,
   input  logic             lo_we,
`ifdef MDU_ABORT_EN
   input  logic             abort,
`endif
   output logic             busy,
   output logic             done,
   output logic [width-1:0] hi,
   output logic [width-1:0] lo
);

   localparam int unsigned CntW = $clog2(width);

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [2*width-1:0]     acc_q, acc_d;
   logic [width-1:0]       opnd_q, opnd_d;
   logic [width-1:0]       a_q, a_d;
   logic [1:0]             op_q, op_d;
   logic                   sa_q, sa_d, sb_q, sb_d;
   logic                   busy_q, busy_d, done_q, done_d;
   logic [width-1:0]       hi_q, hi_d, lo_q, lo_d;

   logic                   a_sign, b_sign;
   logic [width-1:0]       a_mag, b_mag;
   logic [width:0]         mul_sum;
   logic [2*width-1:0]     mul_next;
   logic [width:0]         rem_sh, div_diff;
   logic                   q_bit;
   logic [2*width-1:0]     div_next;
   logic [2*width-1:0]     prod_fix;
   logic [width-1:0]       quo_fix, rem_fix;
   logic                   div_zero;

   // Signed ops (op[0]=0) work on magnitudes; unsigned ops use raw operands.
   assign a_sign = ~op[0] & a[width-1];
   assign b_sign = ~op[0] & b[width-1];
   assign a_mag  = a_sign ? -a : a;
   assign b_mag  = b_sign ? -b : b;

   // Shift-add: multiplier in acc low half, partial product in high half.
   assign mul_sum  = {1'b0, acc_q[2*width-1:width]} +
                     (acc_q[0] ? {1'b0, opnd_q} : {(width+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[width-1:1]};

   // Restoring division: remainder in high half, dividend/quotient in low half.
   assign rem_sh   = acc_q[2*width-1:width-1];
   assign div_diff = rem_sh - {1'b0, opnd_q};
   assign q_bit    = ~div_diff[width];
   assign div_next = {(q_bit ? div_diff[width-1:0] : rem_sh[width-1:0]),
                      acc_q[width-2:0], q_bit};

   assign prod_fix = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quo_fix  = (sa_q ^ sb_q) ? -acc_q[width-1:0] : acc_q[width-1:0];
   assign rem_fix  = sa_q ? -acc_q[2*width-1:width] : acc_q[2*width-1:width];
   assign div_zero = (opnd_q == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      a_d     = a_q;
      op_d    = op_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;

      case (state_q)
         StIdle: begin
            if (hi_we) hi_d = wd;
            if (lo_we) lo_d = wd;
            if (start) begin
               state_d = StCalc;
               cnt_d   = CntW'(width - 1);
               op_d    = op;
               a_d     = a;
               sa_d    = a_sign;
               sb_d    = b_sign;
               opnd_d  = op[1] ? b_mag : a_mag;
               acc_d   = {{width{1'b0}}, (op[1] ? a_mag : b_mag)};
            end
         end
         StCalc: begin
            acc_d = op_q[1] ? div_next : mul_next;
            if (cnt_q == '0) state_d = StFix;
            else             cnt_d   = cnt_q - CntW'(1);
         end
         StFix: begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (!op_q[1]) begin
               hi_d = prod_fix[2*width-1:width];
               lo_d = prod_fix[width-1:0];
            end else if (div_zero) begin
               hi_d = a_q;
               lo_d = '1;
            end else begin
               hi_d = rem_fix;
               lo_d = quo_fix;
            end
         end
         default: state_d = StIdle;
      endcase

`ifdef MDU_ABORT_EN
      // Abort discards the operation, including a FIX load in the same cycle.
      if (abort && state_q != StIdle) begin
         state_d = StIdle;
         done_d  = 1'b0;
         acc_d   = acc_q;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
`endif

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         a_q     <= '0;
         op_q    <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         a_q     <= a_d;
         op_q    <= op_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit (width=32).
// Abort scenario is compiled in when MDU_ABORT_EN is defined.
module tb_mul_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0, wd = '0;
   logic        hi_we = 1'b0, lo_we = 1'b0;
`ifdef MDU_ABORT_EN
   logic        abort = 1'b0;
`endif
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

   mul_div_unit #(.width(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .wd    (wd),
      .hi_we (hi_we),
      .lo_we (lo_we),
`ifdef MDU_ABORT_EN
      .abort (abort),
`endif
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench #1 after the edge that accepts start (edge 1).
   task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op = o; a = x; b = y; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Returns the edge index at which done was seen, or -1 on timeout.
   task automatic wait_done(output int k);
      k = -1;
      for (int e = 1; e <= 60; e++) begin
         if (done) begin
            k = e;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
      end
   endtask

   task automatic test_multu_timing();
      int busy_n = 0, done_n = 0, done_e = -1;
      launch(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      for (int e = 1; e <= 40; e++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (done_e < 0) done_e = e;
         end
         step();
      end
      n_checks++;
      if (busy_n != 33) begin
         n_fail++; $display("FAIL multu_busy_cycles: got %0d want 33", busy_n);
      end
      n_checks++;
      if (done_e != 34) begin
         n_fail++; $display("FAIL multu_done_edge: got %0d want 34", done_e);
      end
      n_checks++;
      if (done_n != 1) begin
         n_fail++; $display("FAIL multu_done_pulses: got %0d want 1", done_n);
      end
      n_checks++;
      if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
         n_fail++; $display("FAIL multu_result: hi=%h lo=%h want fffffffe 00000001", hi, lo);
      end
   endtask

   task automatic test_signed();
      int k;
      launch(OpMult, 32'hFFFF_FFFD, 32'd5);
      wait_done(k);
      n_checks++;
      if (k != 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
         n_fail++;
         $display("FAIL mult_neg: edge=%0d hi=%h lo=%h want 34 ffffffff fffffff1", k, hi, lo);
      end
      step();
      launch(OpDiv, 32'hFFFF_FFF9, 32'd2);
      wait_done(k);
      n_checks++;
      if (k != 34 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
         n_fail++;
         $display("FAIL div_neg: edge=%0d hi=%h lo=%h want 34 ffffffff fffffffd", k, hi, lo);
      end
      step();
      launch(OpMult, 32'd7, 32'hFFFF_FFFA);
      wait_done(k);
      n_checks++;
      if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFD6) begin
         n_fail++; $display("FAIL mult_pos_neg: hi=%h lo=%h want ffffffff ffffffd6", hi, lo);
      end
      // Start in the done cycle is accepted: DIV 20 / -3 -> q=-6, r=2.
      launch(OpDiv, 32'd20, 32'hFFFF_FFFD);
      wait_done(k);
      n_checks++;
      if (k != 34 || hi !== 32'd2 || lo !== 32'hFFFF_FFFA) begin
         n_fail++;
         $display("FAIL div_in_done_cycle: edge=%0d hi=%h lo=%h want 34 00000002 fffffffa",
                  k, hi, lo);
      end
   endtask

   task automatic test_div_corner();
      int k;
      step();
      launch(OpDivu, 32'd100, 32'd0);
      wait_done(k);
      n_checks++;
      if (k != 34 || hi !== 32'h0000_0064 || lo !== 32'hFFFF_FFFF) begin
         n_fail++;
         $display("FAIL divu_by_zero: edge=%0d hi=%h lo=%h want 34 00000064 ffffffff", k, hi, lo);
      end
      step();
      launch(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(k);
      n_checks++;
      if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
         n_fail++; $display("FAIL div_overflow: hi=%h lo=%h want 00000000 80000000", hi, lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      int k;
      step();
      wd = 32'hCAFE_0001; hi_we = 1'b1;
      step();
      wd = 32'hBEEF_0002; hi_we = 1'b0; lo_we = 1'b1;
      step();
      lo_we = 1'b0;
      n_checks++;
      if (hi !== 32'hCAFE_0001 || lo !== 32'hBEEF_0002) begin
         n_fail++; $display("FAIL mthi_mtlo: hi=%h lo=%h want cafe0001 beef0002", hi, lo);
      end
      // MTLO in the same cycle as start lands, then the result overwrites it.
      wd = 32'h1111_1111; lo_we = 1'b1;
      op = OpMultu; a = 32'd9; b = 32'd11; start = 1'b1;
      step();
      start = 1'b0; lo_we = 1'b0;
      n_checks++;
      if (lo !== 32'h1111_1111 || busy !== 1'b1) begin
         n_fail++; $display("FAIL mtlo_with_start: lo=%h busy=%b want 11111111 1", lo, busy);
      end
      wait_done(k);
      n_checks++;
      if (hi !== 32'd0 || lo !== 32'd99) begin
         n_fail++; $display("FAIL result_after_mtlo: hi=%h lo=%h want 00000000 00000063", hi, lo);
      end
   endtask

   task automatic test_busy_ignore();
      int done_n = 0;
      step();
      launch(OpDivu, 32'd50, 32'd7);
      for (int e = 1; e <= 45; e++) begin
         if (e == 5)  begin op = OpMultu; a = 32'd9; b = 32'd3; start = 1'b1; end
         if (e == 6)  start = 1'b0;
         if (e == 10) begin wd = 32'h1234; hi_we = 1'b1; end
         if (e == 11) hi_we = 1'b0;
         if (done) done_n++;
         step();
      end
      n_checks++;
      if (done_n != 1) begin
         n_fail++; $display("FAIL busy_ignore_pulses: got %0d want 1", done_n);
      end
      n_checks++;
      if (hi !== 32'd1 || lo !== 32'd7 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_ignore_result: hi=%h lo=%h busy=%b want 00000001 00000007 0",
                  hi, lo, busy);
      end
   endtask

   task automatic test_reset_mid();
      int k;
      launch(OpMult, 32'd5, 32'd7);
      for (int e = 1; e < 12; e++) step();
      n_checks++;
      if (busy !== 1'b1 || lo !== 32'd7) begin
         n_fail++; $display("FAIL pre_reset: busy=%b lo=%h want 1 00000007", busy, lo);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
         n_fail++;
         $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
      end
      #1 reset = 1'b0;
      step();
      launch(OpMultu, 32'd6, 32'd7);
      wait_done(k);
      n_checks++;
      if (k != 34 || hi !== 32'd0 || lo !== 32'd42) begin
         n_fail++;
         $display("FAIL post_reset_multu: edge=%0d hi=%h lo=%h want 34 00000000 0000002a", k, hi, lo);
      end
   endtask

`ifdef MDU_ABORT_EN
   task automatic test_abort();
      int done_n = 0;
      step();
      wd = 32'hAAAA; hi_we = 1'b1;
      step();
      wd = 32'h5555; hi_we = 1'b0; lo_we = 1'b1;
      step();
      lo_we = 1'b0;
      launch(OpMultu, 32'd3, 32'd4);
      for (int e = 1; e < 20; e++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++; $display("FAIL abort_stop: busy=%b done=%b want 0 0", busy, done);
      end
      for (int e = 0; e < 40; e++) begin
         if (done) done_n++;
         step();
      end
      n_checks++;
      if (done_n != 0 || hi !== 32'hAAAA || lo !== 32'h5555) begin
         n_fail++;
         $display("FAIL abort_retain: done_n=%0d hi=%h lo=%h want 0 0000aaaa 00005555",
                  done_n, hi, lo);
      end
   endtask
`endif

   initial begin
      #2;
      step();
      test_reset();
      #2 reset = 1'b0;
      step();
      test_reset();
      test_multu_timing();
      test_signed();
      test_div_corner();
      test_mthi_mtlo();
      test_busy_ignore();
      test_reset_mid();
`ifdef MDU_ABORT_EN
      test_abort();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
